// File: rtl/ledring_pkg.sv
// ---------------------------------------------------------------------------
// ledring_pkg
// Shared types and constants for the LED ring driver.
//   rgb_t      : one pixel as software sees it, {R, G, B} in bits [23:0]
//   grb_word() : reorders a pixel into the G-R-B byte order used on the wire
//   state_t    : frame sequencer states
//   CTRL_*     : bit positions inside the CTRL register
// ---------------------------------------------------------------------------
package ledring_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BIT,
    LATCH
  } state_t;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_BUSY_BIT    = 0;
  localparam int CTRL_PENDING_BIT = 1;
  localparam int CTRL_NLEDS_LSB   = 8;

  // The pixel strip expects green first, then red, then blue.
  function automatic logic [23:0] grb_word(input rgb_t c);
    return {c.g, c.r, c.b};
  endfunction

endpackage

// File: rtl/ledring_if.sv
// ---------------------------------------------------------------------------
// ledring_if
// Avalon-MM slave bundle for the LED ring driver.
//   avs_address   : word address (ADDR_W bits)
//   avs_write     : write strobe
//   avs_writedata : 32-bit write data
//   avs_read      : read strobe
//   avs_readdata  : 32-bit read data, valid the cycle after avs_read
// The master modport is the bus side, the slave modport is the driver side.
// ---------------------------------------------------------------------------
interface ledring_if #(
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );

endinterface

// File: rtl/ledring_bit_tx.sv
// ---------------------------------------------------------------------------
// ledring_bit_tx
// Times a single NRZ bit slot on the one-wire data line.
//   clk, reset    : system clock, synchronous active-high reset
//   go_i          : start a new slot on the next edge (idle, or last slot cycle)
//   bit_val_i     : value of the bit to send in the slot started by go_i
//   data_o        : registered data line (high for the first T0H/T1H clocks)
//   slot_done_o   : high during the last clock of a running slot
// ---------------------------------------------------------------------------
module ledring_bit_tx
  import ledring_pkg::*;
#(
  parameter int BIT_CYC = 63,
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic go_i,
  input  logic bit_val_i,
  output logic data_o,
  output logic slot_done_o
);

  localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : gBadTiming
    $error("ledring_bit_tx: timing must satisfy 0 < T0H_CYC < T1H_CYC < BIT_CYC");
  end

  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic             bitVal_q, bitVal_d;
  logic             run_q, run_d;
  logic             data_q, data_d;

  assign slot_done_o = run_q && (bitCnt_q == CNT_W'(BIT_CYC - 1));
  assign data_o      = data_q;

  // Next-state for the slot timer. The data line is computed one cycle
  // ahead from the next counter value so that it can come straight out of
  // a flop and still rise on the very edge a slot begins. Every slot starts
  // high because even a 0 bit has a non-zero high time.
  always_comb begin
    bitCnt_d = bitCnt_q;
    bitVal_d = bitVal_q;
    run_d    = run_q;
    data_d   = 1'b0;
    if (go_i) begin
      bitCnt_d = '0;
      bitVal_d = bit_val_i;
      run_d    = 1'b1;
      data_d   = 1'b1;
    end else if (slot_done_o) begin
      bitCnt_d = '0;
      run_d    = 1'b0;
    end else if (run_q) begin
      bitCnt_d = bitCnt_q + 1'b1;
      data_d   = (int'(bitCnt_d) < (bitVal_q ? T1H_CYC : T0H_CYC));
    end
  end

  // Slot timer registers; reset drops the line low immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitCnt_q <= '0;
      bitVal_q <= 1'b0;
      run_q    <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      bitCnt_q <= bitCnt_d;
      bitVal_q <= bitVal_d;
      run_q    <= run_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/ledring_driver.sv
// ---------------------------------------------------------------------------
// ledring_driver
// Avalon-MM slave that streams per-pixel colours to a WS2812-style ring.
//   clk, reset : system clock, synchronous active-high reset
//   avs        : Avalon-MM slave (ledring_if.slave)
//                0..NUM_LEDS-1 : pixel words {8'h0, R, G, B}
//                NUM_LEDS      : CTRL (write bit0 = start; read bit0 busy,
//                                bit1 pending, [15:8] NUM_LEDS)
//   ledring_n  : pin level, inverted data line when INVERT=1
// A frame is every pixel sent G-R-B MSB first, then a low latch gap.
// ---------------------------------------------------------------------------
module ledring_driver
  import ledring_pkg::*;
#(
  parameter int NUM_LEDS  = 16,
  parameter int ADDR_W    = 5,
  parameter int BIT_CYC   = 63,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int RESET_CYC = 4000,
  parameter int INVERT    = 1
) (
  input  logic       clk,
  input  logic       reset,
  ledring_if.slave   avs,
  output logic       ledring_n
);

  localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LAT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_LEDS);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_LEDS - 1);

  if (NUM_LEDS < 1 || NUM_LEDS >= (1 << ADDR_W)) begin : gBadNumLeds
    $error("ledring_driver: NUM_LEDS must be in 1 .. 2**ADDR_W-1");
  end

  rgb_t             pixBuf_q [NUM_LEDS];
  state_t           state_q, state_d;
  logic [PIX_W-1:0] pixIdx_q, pixIdx_d;
  logic [4:0]       bitIdx_q, bitIdx_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [LAT_W-1:0] latchCnt_q, latchCnt_d;
  logic             pending_q, pending_d;
  logic [31:0]      readData_q, readData_d;
  logic             startWr;
  logic             busy;
  logic             txGo;
  logic             txBitVal;
  logic             txData;
  logic             slotDone;
  logic [23:0]      loadWord;
  logic             unusedWdata;

  assign startWr     = avs.avs_write && (avs.avs_address == CTRL_ADDR)
                       && avs.avs_writedata[CTRL_START_BIT];
  assign busy        = (state_q != IDLE);
  assign unusedWdata = ^avs.avs_writedata[31:24];
  assign ledring_n   = (INVERT != 0) ? ~txData : txData;
  assign avs.avs_readdata = readData_q;

  // Pixel register file. Writes land at any time, even mid-frame; the
  // sequencer takes its own copy of each pixel when it loads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) pixBuf_q[i] <= '0;
    end else if (avs.avs_write) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (avs.avs_address == ADDR_W'(i)) pixBuf_q[i] <= rgb_t'(avs.avs_writedata[23:0]);
      end
    end
  end

  // Pick the pixel the sequencer is about to load, already in wire order.
  always_comb begin
    loadWord = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (pixIdx_q == PIX_W'(i)) loadWord = grb_word(pixBuf_q[i]);
    end
  end

  // Read mux: pixel words come back zero-extended, CTRL reports status,
  // everything else reads as zero.
  always_comb begin
    readData_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (avs.avs_address == ADDR_W'(i)) readData_d = {8'h00, pixBuf_q[i]};
    end
    if (avs.avs_address == CTRL_ADDR) begin
      readData_d[CTRL_BUSY_BIT]           = busy;
      readData_d[CTRL_PENDING_BIT]        = pending_q;
      readData_d[CTRL_NLEDS_LSB +: 8]     = 8'(NUM_LEDS);
    end
  end

  // Read data is registered so the bus sees a fixed latency of one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData_q <= '0;
    end else if (avs.avs_read) begin
      readData_q <= readData_d;
    end
  end

  // Frame sequencer. LOAD copies one pixel into the shift register and
  // kicks the bit timer; BIT walks the 24 bits, reloading the timer on the
  // last clock of each slot so slots run back to back; LATCH holds the line
  // low for the latch gap. A start seen while busy is remembered as pending,
  // and a start arriving on the final LATCH clock is folded into the same
  // decision so the next frame follows with no IDLE cycle.
  always_comb begin
    state_d    = state_q;
    pixIdx_d   = pixIdx_q;
    bitIdx_d   = bitIdx_q;
    shreg_d    = shreg_q;
    latchCnt_d = latchCnt_q;
    pending_d  = pending_q;
    txGo       = 1'b0;
    txBitVal   = 1'b0;

    if (startWr && busy) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (startWr) begin
          state_d  = LOAD;
          pixIdx_d = '0;
        end
      end
      LOAD: begin
        shreg_d  = loadWord;
        bitIdx_d = 5'd23;
        txGo     = 1'b1;
        txBitVal = loadWord[23];
        state_d  = BIT;
      end
      BIT: begin
        if (slotDone) begin
          if (bitIdx_q != 5'd0) begin
            shreg_d  = {shreg_q[22:0], 1'b0};
            bitIdx_d = bitIdx_q - 5'd1;
            txGo     = 1'b1;
            txBitVal = shreg_q[22];
          end else if (pixIdx_q == LAST_PIX) begin
            latchCnt_d = '0;
            state_d    = LATCH;
          end else begin
            pixIdx_d = pixIdx_q + 1'b1;
            state_d  = LOAD;
          end
        end
      end
      LATCH: begin
        latchCnt_d = latchCnt_q + 1'b1;
        if (latchCnt_q == LAT_W'(RESET_CYC - 1)) begin
          if (pending_q || startWr) begin
            pending_d = 1'b0;
            pixIdx_d  = '0;
            state_d   = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pixIdx_q   <= '0;
      bitIdx_q   <= '0;
      shreg_q    <= '0;
      latchCnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pixIdx_q   <= pixIdx_d;
      bitIdx_q   <= bitIdx_d;
      shreg_q    <= shreg_d;
      latchCnt_q <= latchCnt_d;
      pending_q  <= pending_d;
    end
  end

  ledring_bit_tx #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC)
  ) uBitTx (
    .clk         (clk),
    .reset       (reset),
    .go_i        (txGo),
    .bit_val_i   (txBitVal),
    .data_o      (txData),
    .slot_done_o (slotDone)
  );

endmodule

// File: tb/tb_ledring_driver.sv
// ---------------------------------------------------------------------------
// tb_ledring_driver
// Self-checking bench for ledring_driver with a small ring and short timing.
// A line monitor turns the pin into a list of pulse start times and widths;
// the expected frame is built from the log of pixel writes and the rule that
// each pixel is sampled as its LOAD cycle ends.
// ---------------------------------------------------------------------------
module tb_ledring_driver;

  localparam int NUM_LEDS  = 2;
  localparam int ADDR_W    = 5;
  localparam int BIT_CYC   = 10;
  localparam int T0H_CYC   = 3;
  localparam int T1H_CYC   = 7;
  localparam int RESET_CYC = 20;
  localparam int INVERT    = 1;
  localparam int PIX_CYC   = 24 * BIT_CYC + 1;
  localparam int FRAME_CYC = NUM_LEDS * PIX_CYC + RESET_CYC;

  typedef struct {
    int          edgeN;
    int          idx;
    logic [23:0] val;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic ledring_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int highLen = 0;
  int riseQ[$];
  int widthQ[$];
  wr_t wrLog[$];

  ledring_if #(.ADDR_W(ADDR_W)) avsBus ();

  ledring_driver #(
    .NUM_LEDS  (NUM_LEDS),
    .ADDR_W    (ADDR_W),
    .BIT_CYC   (BIT_CYC),
    .T0H_CYC   (T0H_CYC),
    .T1H_CYC   (T1H_CYC),
    .RESET_CYC (RESET_CYC),
    .INVERT    (INVERT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .avs       (avsBus),
    .ledring_n (ledring_n)
  );

  // 10 ns clock; cyc numbers the rising edges seen so far.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: data is the inverse of the pin. Records the edge number of
  // each rising pulse and its width in clocks.
  always @(negedge clk) begin
    if (ledring_n === 1'b0) begin
      if (highLen == 0) riseQ.push_back(cyc);
      highLen++;
    end else if (highLen != 0) begin
      widthQ.push_back(highLen);
      highLen = 0;
    end
  end

  // Central comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to the falling edge at which cyc == target.
  task automatic gotoNeg(input int target);
    if (cyc > target) checkOutput("schedule", cyc, target);
    while (cyc < target) @(negedge clk);
  endtask

  // Bus write sampled by the DUT at rising edge 'target'.
  task automatic applyStimulus(input int addr, input logic [31:0] data, input int target);
    gotoNeg(target - 1);
    avsBus.avs_address   = ADDR_W'(addr);
    avsBus.avs_writedata = data;
    avsBus.avs_write     = 1'b1;
    @(negedge clk);
    avsBus.avs_write     = 1'b0;
    if (addr < NUM_LEDS) wrLog.push_back('{edgeN: target, idx: addr, val: data[23:0]});
  endtask

  // Bus read sampled at rising edge 'target'; compared once readdata settles.
  task automatic checkRead(input string tag, input int addr, input int target,
                           input logic [31:0] expected);
    gotoNeg(target - 1);
    avsBus.avs_address = ADDR_W'(addr);
    avsBus.avs_read    = 1'b1;
    @(negedge clk);
    avsBus.avs_read    = 1'b0;
    checkOutput(tag, avsBus.avs_readdata, expected);
  endtask

  function automatic logic [31:0] ctrlWord(input int busyV, input int pendV);
    return (NUM_LEDS << 8) + (pendV << 1) + busyV;
  endfunction

  // Latest value written to a pixel at an edge strictly before 'limit'.
  function automatic logic [23:0] pixelAt(input int idx, input int limit);
    logic [23:0] v = '0;
    foreach (wrLog[i]) if (wrLog[i].idx == idx && wrLog[i].edgeN < limit) v = wrLog[i].val;
    return v;
  endfunction

  function automatic int wireWord(input int rgb);
    int r = (rgb >> 16) & 255;
    int g = (rgb >> 8) & 255;
    int b = rgb & 255;
    return (g << 16) + (r << 8) + b;
  endfunction

  // Compare one whole frame whose LOAD began at edge s.
  task automatic checkFrame(input int s);
    for (int p = 0; p < NUM_LEDS; p++) begin
      int word = wireWord(int'(pixelAt(p, s + p * PIX_CYC + 1)));
      for (int k = 0; k < 24; k++) begin
        int bitV = (word >> (23 - k)) & 1;
        int r = (riseQ.size() > 0) ? riseQ.pop_front() : -1;
        int w = (widthQ.size() > 0) ? widthQ.pop_front() : -1;
        checkOutput($sformatf("rise f%0d p%0d b%0d", s, p, k), r, s + p * PIX_CYC + 1 + k * BIT_CYC);
        checkOutput($sformatf("width f%0d p%0d b%0d", s, p, k), w, bitV ? T1H_CYC : T0H_CYC);
      end
    end
  endtask

  task automatic clearMonitor();
    riseQ.delete();
    widthQ.delete();
    highLen = 0;
  endtask

  initial begin
    int s;
    int s2;
    logic [31:0] rnd;

    reset = 1'b1;
    avsBus.avs_address   = '0;
    avsBus.avs_write     = 1'b0;
    avsBus.avs_writedata = '0;
    avsBus.avs_read      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state and register map");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idle line", ledring_n, 1'b1);
    end
    checkRead("ctrl after reset", NUM_LEDS, cyc + 1, 32'h0000_0200);
    checkRead("pix0 after reset", 0, cyc + 1, 32'h0);
    rnd = $urandom;
    applyStimulus(1, rnd, cyc + 1);
    checkRead("pix1 readback", 1, cyc + 1, {8'h00, rnd[23:0]});
    applyStimulus(5, $urandom, cyc + 1);
    checkRead("unmapped read", 5, cyc + 1, 32'h0);
    applyStimulus(NUM_LEDS, $urandom & 32'hFFFF_FFFE, cyc + 1);
    repeat (5) @(negedge clk);
    checkRead("ctrl no start", NUM_LEDS, cyc + 1, ctrlWord(0, 0));
    checkOutput("no frame on bit0=0", riseQ.size(), 0);

    $display("[TB] directed red/blue frame");
    applyStimulus(0, 32'h00FF_0000, cyc + 1);
    applyStimulus(1, 32'h0000_00FF, cyc + 1);
    s = cyc + 1;
    applyStimulus(NUM_LEDS, 32'h1, s);
    checkRead("busy mid frame", NUM_LEDS, s + 250, ctrlWord(1, 0));
    checkRead("busy last latch", NUM_LEDS, s + FRAME_CYC, ctrlWord(1, 0));
    checkRead("idle after frame", NUM_LEDS, s + FRAME_CYC + 1, ctrlWord(0, 0));
    checkFrame(s);

    $display("[TB] pending start collapses into one extra frame");
    s = cyc + 1;
    applyStimulus(NUM_LEDS, 32'h1, s);
    applyStimulus(NUM_LEDS, 32'h1, s + 100);
    applyStimulus(NUM_LEDS, 32'hFFFF_FFFF, s + 200);
    checkRead("pending set", NUM_LEDS, s + 300, ctrlWord(1, 1));
    checkRead("pending at latch end", NUM_LEDS, s + FRAME_CYC, ctrlWord(1, 1));
    checkRead("pending consumed", NUM_LEDS, s + FRAME_CYC + 1, ctrlWord(1, 0));
    checkFrame(s);
    s2 = s + FRAME_CYC;
    checkRead("second frame busy", NUM_LEDS, s2 + 300, ctrlWord(1, 0));
    checkRead("second frame end", NUM_LEDS, s2 + FRAME_CYC + 1, ctrlWord(0, 0));
    checkFrame(s2);
    repeat (5) @(negedge clk);
    checkOutput("no third frame", riseQ.size(), 0);

    $display("[TB] pixel writes during a frame");
    applyStimulus(0, $urandom, cyc + 1);
    applyStimulus(1, $urandom, cyc + 1);
    s = cyc + 1;
    applyStimulus(NUM_LEDS, 32'h1, s);
    applyStimulus(1, 32'h0001_0101, s + 50);
    applyStimulus(0, $urandom, s + 60);
    applyStimulus(NUM_LEDS, 32'h1, s + 100);
    checkRead("busy before rerun", NUM_LEDS, s + FRAME_CYC, ctrlWord(1, 1));
    checkFrame(s);
    s2 = s + FRAME_CYC;
    checkRead("rerun end", NUM_LEDS, s2 + FRAME_CYC + 1, ctrlWord(0, 0));
    checkFrame(s2);

    $display("[TB] random frames with random mid-frame writes");
    for (int it = 0; it < 3; it++) begin
      for (int p = 0; p < NUM_LEDS; p++) applyStimulus(p, $urandom, cyc + 1);
      s = cyc + 1;
      applyStimulus(NUM_LEDS, 32'h1, s);
      applyStimulus($urandom_range(0, NUM_LEDS - 1), $urandom, s + 2 + $urandom_range(0, 470));
      checkRead($sformatf("random frame %0d end", it), NUM_LEDS, s + FRAME_CYC + 1, ctrlWord(0, 0));
      checkFrame(s);
    end

    $display("[TB] reset in the middle of a bit");
    applyStimulus(0, ($urandom & 32'h00FF_7FFF) | 32'h0000_8000, cyc + 1);
    applyStimulus(1, $urandom, cyc + 1);
    s = cyc + 1;
    applyStimulus(NUM_LEDS, 32'h1, s);
    applyStimulus(NUM_LEDS, 32'h1, s + 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset aborts bit", ledring_n, 1'b1);
    reset = 1'b0;
    wrLog.delete();
    repeat (5) @(negedge clk);
    clearMonitor();
    checkRead("ctrl after abort", NUM_LEDS, cyc + 1, ctrlWord(0, 0));
    checkRead("pix0 after abort", 0, cyc + 1, 32'h0);
    checkRead("pix1 after abort", 1, cyc + 1, 32'h0);
    repeat (20) @(negedge clk);
    checkOutput("line idle after abort", riseQ.size(), 0);

    $display("[TB] start on the last latch clock");
    applyStimulus(0, $urandom, cyc + 1);
    applyStimulus(1, $urandom, cyc + 1);
    s = cyc + 1;
    applyStimulus(NUM_LEDS, 32'h1, s);
    applyStimulus(NUM_LEDS, 32'h1, s + FRAME_CYC);
    checkRead("busy after late start", NUM_LEDS, s + FRAME_CYC + 1, ctrlWord(1, 0));
    checkFrame(s);
    s2 = s + FRAME_CYC;
    checkRead("late start frame end", NUM_LEDS, s2 + FRAME_CYC + 1, ctrlWord(0, 0));
    checkFrame(s2);
    repeat (5) @(negedge clk);
    checkOutput("no stray pulses", riseQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ledring_driver.md
Name: ledring_driver

Overview:
- Avalon-MM slave that drives the display board's WS2812-style LED pixel ring through the inverted LEDRINGn pin.
- It is the output-direction counterpart of the button shift-register reader: software writes per-pixel colours, then triggers a frame.
- The block serialises the frame as NRZ one-wire pulses, followed by a latch gap.
- Instantiated as a Qsys component in clarvi_soc; its conduit is exported to LEDRINGn.

Parameters:
- NUM_LEDS, 16: number of pixels in the ring; must satisfy 1 ≤ NUM_LEDS < 2**ADDR_W.
- ADDR_W, 5: Avalon word-address width.
- BIT_CYC, 63: clocks per bit slot (1.26 us at 50 MHz).
- T0H_CYC, 20: high time for a 0 bit (0.4 us).
- T1H_CYC, 40: high time for a 1 bit (0.8 us).
- RESET_CYC, 4000: low latch gap after the last bit (80 us).
- INVERT, 1: 1 means the pin is driven with the inverse of the data line.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- avs_address  in  ADDR_W  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, registered, fixed read latency 1.
- ledring_n  out  1  pin level: ~data when INVERT=1, otherwise data.

Behaviour:
- Register map:
  - Addresses 0..NUM_LEDS-1: pixel word, bits [23:16]=R, [15:8]=G, [7:0]=B. Bits [31:24] are ignored on write and read back as 0.
  - Address NUM_LEDS is CTRL. Write bit0=1 requests a start; all other bits are ignored. Read returns bit0=busy, bit1=pending, [15:8]=NUM_LEDS, other bits 0.
  - Other addresses: writes are ignored, reads return 0.
- Reset values:
  - pixel buffer all 0; busy=0; pending=0; avs_readdata=0.
  - data line low, so ledring_n=1 when INVERT=1.
  - state IDLE.
  - Reset mid-frame aborts within the reset cycle and the line is idle on the next edge.
- Reads: avs_readdata is updated on the cycle after avs_read. Reads have no side effects.
- Pixel writes are accepted at any time, including while busy. The transmitter snapshots a pixel into its 24-bit shift register in LOAD, so a write takes effect for that pixel only if it lands before the pixel is loaded. Tearing between pixels is permitted.
- Wire order per pixel is G[7:0], R[7:0], B[7:0], MSB first, i.e. shift word = {G,R,B}. Pixels are sent in order 0..NUM_LEDS-1.
- State machine IDLE -> LOAD -> BIT -> LATCH:
  - IDLE: data low, busy=0. A start write moves to LOAD on the next edge (pix_idx=0) and sets busy=1 on that same edge.
  - LOAD (1 cycle): shift register <= buffer[pix_idx], bit_idx=23, bit_cnt=0; go to BIT.
  - BIT: data = (bit_cnt < (shreg[23] ? T1H_CYC : T0H_CYC)); bit_cnt counts 0..BIT_CYC-1.
    - At BIT_CYC-1 with bit_idx>0: shift left, bit_idx--, bit_cnt=0.
    - At bit_idx=0 with pix_idx<NUM_LEDS-1: pix_idx++, go to LOAD.
    - At bit_idx=0 with the last pixel: go to LATCH.
  - LOAD therefore inserts one extra low clock between pixels, which is within WS2812 tolerance. This is a documented property, not a bug.
  - LATCH: data low for RESET_CYC clocks.
    - At the end, if pending=1: clear pending and go to LOAD with pix_idx=0; busy stays 1.
    - Otherwise go to IDLE, with busy=0 on the edge that enters IDLE.
- Start write while busy sets pending=1. Multiple starts collapse into one pending frame.
- Start write in the same cycle LATCH completes (pending=0): treated as pending, and the next frame starts immediately without going through IDLE.
- Timing:
  - The first rising edge of data occurs 2 clocks after the start write cycle (write edge -> LOAD -> BIT).
  - Frame duration from entering LOAD to entering IDLE = NUM_LEDS*(24*BIT_CYC+1) + RESET_CYC clocks.
- Counter widths are sized with $clog2 of the largest parameter. Parameter constraint: 0 < T0H_CYC < T1H_CYC < BIT_CYC; violations are a static elaboration assertion.
- ledring_n is driven from a flop, with no combinational path from the Avalon inputs.

Decomposition:
- Package ledring_pkg holds:
  - typedef rgb_t: packed struct with r, g, b as logic[7:0].
  - function grb_word(rgb_t) returning logic[23:0].
  - typedef enum state_t {IDLE, LOAD, BIT, LATCH}.
  - CTRL bit-index constants.
- Sub-module ledring_bit_tx holds the bit slot timer: inputs bit_val and go, outputs data and slot_done. The top level owns the register file, pixel sequencing, pending flag and latch gap.

Test Plan:
All scenarios use NUM_LEDS=2, BIT_CYC=10, T0H_CYC=3, T1H_CYC=7, RESET_CYC=20, INVERT=1.
1. Reset, then sample for 50 clocks -> ledring_n=1 throughout; CTRL read returns 0x0000_0200; pixel 0 reads 0.
2. Write pix0=0x00FF0000 (R), pix1=0x000000FF (B), then start -> data first rises 2 clocks after the start write. Decoded 48 bits are G=00,R=FF,B=00,G=00,R=00,B=FF. Each 1 bit is high 7 clocks, each 0 bit is high 3 clocks. Slots are 10 clocks, plus 1 low clock between pixels. busy reads 1 until 2*(24*10+1)+20=502 clocks after LOAD entry.
3. Start written twice during a frame -> pending reads 1; exactly one extra frame follows, immediately after LATCH; busy stays 1 continuously; then IDLE.
4. Write pix1=0x00010101 while pixel 0 is transmitting -> the new value appears on the wire in the same frame. Write pix0 during the same frame -> the new pix0 value appears only in the next frame.
5. Assert reset for 1 cycle in the middle of a bit-high phase -> ledring_n=1 on the next edge; busy=0 and pending=0; pixel buffer reads 0.
6. Start write on the exact last LATCH cycle -> no IDLE cycle; a new LOAD follows; busy never drops.
